mux_n_pipe: RTL and testbench

Parametrised N-way, WIDTH-bit registered selector with a valid/ready handshake on both sides. It is the pipelined successor of the fixed 4:1 32-bit combinational selector, used in the datapath wherever a selected operand must cross a pipeline register. Out-of-range selects are flagged instead of driving X.

---
 rtl/mux_n_pkg.sv | 26 ++
 rtl/mux_n_comb.sv | 33 +++
 rtl/mux_n_pipe.sv | 182 ++++++++++++++++++
 tb/tb_mux_n_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pkg.sv
// -----------------------------------------------------------------------------
// mux_n_pkg
// Shared types and constants for the registered N:1 selector (mux_n_pipe).
//   mux_state_e : output-stage occupancy (EMPTY, FULL/ONE, TWO)
//   DEF_WIDTH   : default channel data width
//   DEF_N       : default channel count
//   sel_width() : select width for N channels (clog2, minimum 1)
// -----------------------------------------------------------------------------
package mux_n_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;

  // ST_FULL is the one-word state; with the skid register enabled it is the
  // "ONE" state and ST_TWO means the skid register is also occupied.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_TWO   = 2'd2
  } mux_state_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : mux_n_pkg

// File: rtl/mux_n_comb.sv
// -----------------------------------------------------------------------------
// mux_n_comb
// Pure combinational N:1 selector of WIDTH-bit channels.
//   data_i : flattened channels, channel k = data_i[k*WIDTH +: WIDTH]
//   sel_i  : channel select
//   data_o : selected channel, or 0 when sel_i >= N
//   err_o  : 1 when sel_i >= N (out-of-range select)
// -----------------------------------------------------------------------------
module mux_n_comb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               err_o
);

  // Start from "no channel matched" so an out-of-range select yields a clean
  // zero with the error flag rather than an X.
  always_comb begin
    data_o = '0;
    err_o  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = data_i[k*WIDTH +: WIDTH];
        err_o  = 1'b0;
      end
    end
  end

endmodule : mux_n_comb

// File: rtl/mux_n_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_pipe
// Registered N-way, WIDTH-bit selector with valid/ready on both sides.
// Out-of-range selects load zero and raise a sticky sel_err.
//
// Build option: define MUXN_SKID_EN to add a one-entry skid register so that
// in_ready is driven from state only (no combinational path from out_ready).
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data [N*WIDTH]   : flattened input channels
//   in_sel  [SEL_W]     : channel select, sampled with in_data
//   in_valid / in_ready : upstream handshake
//   out_data [WIDTH]    : registered selected word
//   out_sel  [SEL_W]    : registered select of that word
//   out_valid/out_ready : downstream handshake
//   sel_err             : sticky out-of-range-select flag
//   err_clr             : clears sel_err (a new error in the same cycle wins)
//   dbg_state           : current occupancy state, for observation
//
// Handshake: a word moves on a rising edge where valid && ready are both high.
// A producer holding valid may not be relied on to wait; a valid without ready
// is simply ignored. out_valid only drops after an output transfer, and
// out_data/out_sel stay stable while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module mux_n_pipe
  import mux_n_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N     = DEF_N,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  input  logic               err_clr,
  output mux_state_e         dbg_state
);

  mux_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic             in_xfer;
  logic             out_xfer;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_comb (
    .data_i (in_data),
    .sel_i  (in_sel),
    .data_o (mux_data),
    .err_o  (mux_err)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;
  assign dbg_state = state_q;

  // Error is judged at acceptance, whichever register the word lands in.
  always_comb begin
    sel_err_d = sel_err_q;
    if (in_xfer && mux_err) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

`ifdef MUXN_SKID_EN

  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;

  // Depends only on state (and reset), never on out_ready.
  assign in_ready = rst_n && (state_q != ST_TWO);

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_data_d = mux_data;
          out_sel_d  = in_sel;
          state_d    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer && in_xfer) begin
          out_data_d = mux_data;
          out_sel_d  = in_sel;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer) begin
          // Output stalled: park the new word behind the current one.
          skid_data_d = mux_data;
          skid_sel_d  = in_sel;
          state_d     = ST_TWO;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          out_data_d = skid_data_q;
          out_sel_d  = skid_sel_q;
          state_d    = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

`else

  // A full stage can still accept when the current word leaves this cycle.
  assign in_ready = rst_n && ((state_q == ST_EMPTY) || out_ready);

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    case (state_q)
      ST_EMPTY, ST_FULL: begin
        if (in_xfer) begin
          out_data_d = mux_data;
          out_sel_d  = in_sel;
          state_d    = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      sel_err_q  <= sel_err_d;
    end
  end

endmodule : mux_n_pipe

// File: tb/tb_mux_n_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_n_pipe
// Drives an N=4 and an N=3 instance of mux_n_pipe in lockstep from the same
// stimulus (the N=3 instance sees the lower three channels). A queue-based
// reference model tracks the words each instance should hold.
// -----------------------------------------------------------------------------
module tb_mux_n_pipe;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4*W-1:0] in_data   = '0;
  logic [1:0]     in_sel    = '0;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b0;
  logic           err_clr   = 1'b0;

  logic           in_ready4, out_valid4, sel_err4;
  logic [W-1:0]   out_data4;
  logic [1:0]     out_sel4;
  mux_n_pkg::mux_state_e dbg4;

  logic           in_ready3, out_valid3, sel_err3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_sel3;
  mux_n_pkg::mux_state_e dbg3;

  mux_n_pipe #(.WIDTH(W), .N(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_sel   (out_sel4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .sel_err   (sel_err4),
    .err_clr   (err_clr),
    .dbg_state (dbg4)
  );

  mux_n_pipe #(.WIDTH(W), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data[3*W-1:0]),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .sel_err   (sel_err3),
    .err_clr   (err_clr),
    .dbg_state (dbg3)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];    // words expected from the N=4 instance
  logic [W-1:0] exp3_q[$];   // words expected from the N=3 instance
  logic [1:0]   sel_q[$];    // select recorded with each word
  bit           m_err4 = 1'b0;
  bit           m_err3 = 1'b0;

  localparam logic [4*W-1:0] ABCD =
    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model by the rising edge that follows.
  task automatic step(input logic v, input logic [1:0] s, input logic [4*W-1:0] d,
                      input logic ordy, input logic clr);
    logic   exp_rdy;
    logic   acc;
    logic   pop;
    logic [W-1:0] word;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    err_clr   = clr;
    #1;
`ifdef MUXN_SKID_EN
    exp_rdy = (exp_q.size() < 2);
`else
    exp_rdy = (exp_q.size() == 0) || ordy;
`endif
    chk_b("in_ready4", in_ready4, exp_rdy);
    chk_b("in_ready3", in_ready3, exp_rdy);
    chk_b("out_valid4", out_valid4, exp_q.size() > 0);
    chk_b("out_valid3", out_valid3, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk_w("out_data4", out_data4, exp_q[0]);
      chk_w("out_data3", out_data3, exp3_q[0]);
      chk_w("out_sel4", {30'd0, out_sel4}, {30'd0, sel_q[0]});
      chk_w("out_sel3", {30'd0, out_sel3}, {30'd0, sel_q[0]});
    end
    chk_b("sel_err4", sel_err4, m_err4);
    chk_b("sel_err3", sel_err3, m_err3);

    pop = (exp_q.size() > 0) && ordy;
    acc = v && exp_rdy;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(exp3_q.pop_front());
      void'(sel_q.pop_front());
    end
    if (acc) begin
      word = d[s*W +: W];
      exp_q.push_back(word);
      exp3_q.push_back((s < 2'd3) ? word : '0);
      sel_q.push_back(s);
    end
    if (clr) m_err4 = 1'b0;
    if (acc && s == 2'd3) m_err3 = 1'b1;
    else if (clr)         m_err3 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("rst_out_valid4", out_valid4, 1'b0);
    chk_b("rst_out_valid3", out_valid3, 1'b0);
    chk_w("rst_out_data4", out_data4, '0);
    chk_w("rst_out_data3", out_data3, '0);
    chk_b("rst_sel_err3", sel_err3, 1'b0);
    chk_b("rst_in_ready4", in_ready4, 1'b0);
    exp_q.delete();
    exp3_q.delete();
    sel_q.delete();
    m_err4 = 1'b0;
    m_err3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [4*W-1:0] rd;

    // Reset state while rst_n is held low.
    #2;
    chk_b("init_out_valid4", out_valid4, 1'b0);
    chk_b("init_in_ready4", in_ready4, 1'b0);
    chk_w("init_out_data4", out_data4, '0);
    chk_w("init_out_sel4", {30'd0, out_sel4}, '0);
    chk_b("init_sel_err3", sel_err3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, sel=2, visible one cycle later.
    step(1'b1, 2'd2, ABCD, 1'b1, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    chk_w("tp_sel2_data", out_data4, 32'h33333333);
    chk_b("tp_sel2_err", sel_err4, 1'b0);

    // Back-to-back stream A,B,C,D.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), ABCD, 1'b1, 1'b0);
    chk_w("tp_stream_last", out_data4, 32'h33333333);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    chk_w("tp_stream_d", out_data4, 32'h44444444);

    // Stall with sel=1 held for 5 cycles, in_valid toggling.
    step(1'b1, 2'd1, ABCD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'(i % 2), 2'd3, ABCD, 1'b0, 1'b0);
    chk_w("tp_stall_hold", out_data4, 32'h22222222);
`ifndef MUXN_SKID_EN
    chk_b("tp_stall_in_ready", in_ready4, 1'b0);
`endif
    step(1'b1, 2'd0, ABCD, 1'b1, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);

    // Out-of-range select on N=3; sticky error; clear vs set priority.
    step(1'b1, 2'd3, ABCD, 1'b1, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    chk_w("tp_oor_data3", out_data3, '0);
    chk_b("tp_oor_err3", sel_err3, 1'b1);
    step(1'b1, 2'd3, ABCD, 1'b1, 1'b1);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b1);
    chk_b("tp_set_wins", sel_err3, 1'b1);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    chk_b("tp_cleared", sel_err3, 1'b0);

    // Asynchronous reset while FULL with the error flag set.
    step(1'b1, 2'd3, ABCD, 1'b0, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, ABCD, 1'b1, 1'b0);

`ifdef MUXN_SKID_EN
    // Two words into a stalled output, then drain in order.
    step(1'b1, 2'd0, ABCD, 1'b0, 1'b0);
    step(1'b1, 2'd1, ABCD, 1'b0, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b0, 1'b0);
    chk_b("tp_skid_full", in_ready4, 1'b0);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    chk_w("tp_skid_a", out_data4, 32'h11111111);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
    chk_w("tp_skid_b", out_data4, 32'h22222222);
    chk_b("tp_skid_ready", in_ready4, 1'b1);
    step(1'b0, 2'd0, ABCD, 1'b1, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rd,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end
    // Drain.
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_n_pipe
